// File: rtl/t05_mem_responder_if.sv
// Word-wide memory bus between the responder (master) and a memory/bus slave.
// The strobes are single-cycle; busy_i low ends the access and validates rdata_i.
interface t05_mem_responder_if;
    logic [31:0] adr_o;
    logic [31:0] wdata_o;
    logic        read_o;
    logic        write_o;
    logic [3:0]  sel_o;
    logic        busy_i;
    logic [31:0] rdata_i;

    modport master (
        output adr_o, wdata_o, read_o, write_o, sel_o,
        input  busy_i, rdata_i
    );

    modport slave (
        input  adr_o, wdata_o, read_o, write_o, sel_o,
        output busy_i, rdata_i
    );
endinterface

// File: rtl/t05_mem_responder.sv
// CPU load/store responder: turns held read/write request levels into one bus
// access, stalls the pipeline until it completes, and flags misalignment or timeout.
module t05_mem_responder #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic                        clk,
    input  logic                        nRst,
    input  logic                        mem_read,
    input  logic                        mem_write,
    input  logic [31:0]                 read_ad,
    input  logic [31:0]                 write_ad,
    input  logic [31:0]                 write_data,
    t05_mem_responder_if.master         bus,
    output logic [31:0]                 rdata_o,
    output logic                        freeze,
    output logic                        done,
    output logic                        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q,    state_d;
    logic [31:0] adr_q,      adr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [3:0]  sel_q,      sel_d;
    logic        read_q,     read_d;
    logic        write_q,    write_d;
    logic [31:0] rdata_q,    rdata_d;
    logic        done_q,     done_d;
    logic        err_q,      err_d;
    logic        is_write_q, is_write_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    // Outputs are registered so that they describe the state being entered.
    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        read_d     = 1'b0;
        write_d    = 1'b0;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        err_d      = err_q;
        is_write_d = is_write_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (mem_write) begin
                    is_write_d = 1'b1;
                    if (write_ad[1:0] != 2'b00) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        state_d    = S_WRITE;
                        write_d    = 1'b1;
                        adr_d      = {write_ad[31:2], 2'b00};
                        wdata_d    = write_data;
                        sel_d      = 4'hF;
                        wait_cnt_d = 8'd0;
                    end
                end else if (mem_read) begin
                    is_write_d = 1'b0;
                    if (read_ad[1:0] != 2'b00) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        state_d    = S_READ;
                        read_d     = 1'b1;
                        adr_d      = {read_ad[31:2], 2'b00};
                        sel_d      = 4'hF;
                        wait_cnt_d = 8'd0;
                    end
                end
            end
            S_READ,
            S_WRITE: state_d = S_WAIT;
            S_WAIT: begin
                if (!bus.busy_i) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    sel_d   = 4'h0;
                    if (!is_write_q) begin
                        rdata_d = bus.rdata_i;
                    end
                end else if (wait_cnt_q == TIMEOUT) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    sel_d   = 4'h0;
                    rdata_d = 32'h0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= S_IDLE;
            adr_q      <= 32'h0;
            wdata_q    <= 32'h0;
            sel_q      <= 4'h0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            rdata_q    <= 32'h0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            is_write_q <= 1'b0;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            read_q     <= read_d;
            write_q    <= write_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            is_write_q <= is_write_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Stall is gated by nRst so a request held during reset cannot freeze the PC.
    assign freeze = nRst &&
                    (((state_q == S_IDLE) && (mem_read || mem_write)) ||
                     (state_q == S_READ) || (state_q == S_WRITE) || (state_q == S_WAIT));

    assign bus.adr_o   = adr_q;
    assign bus.wdata_o = wdata_q;
    assign bus.sel_o   = sel_q;
    assign bus.read_o  = read_q;
    assign bus.write_o = write_q;
    assign rdata_o     = rdata_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_t05_mem_responder.sv
// Directed bench for t05_mem_responder: read, waited write, simultaneous request,
// misalignment, timeout (TIMEOUT=4) and asynchronous reset in the middle of an access.
module tb_t05_mem_responder;

    logic        clk;
    logic        nRst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] read_ad;
    logic [31:0] write_ad;
    logic [31:0] write_data;
    logic [31:0] rdata_o;
    logic        freeze;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    t05_mem_responder_if bus_if ();

    t05_mem_responder #(.TIMEOUT(8'd4)) dut (
        .clk        (clk),
        .nRst       (nRst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .read_ad    (read_ad),
        .write_ad   (write_ad),
        .write_data (write_data),
        .bus        (bus_if),
        .rdata_o    (rdata_o),
        .freeze     (freeze),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        nRst           = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        read_ad        = 32'h0;
        write_ad       = 32'h0;
        write_data     = 32'h0;
        bus_if.busy_i  = 1'b0;
        bus_if.rdata_i = 32'h0;

        // Reset values, with a request held to prove freeze stays low.
        #3;
        mem_read = 1'b1;
        #1;
        checkOutput("rst_freeze", {31'h0, freeze}, 32'h0);
        checkOutput("rst_adr", bus_if.adr_o, 32'h0);
        checkOutput("rst_wdata", bus_if.wdata_o, 32'h0);
        checkOutput("rst_sel", {28'h0, bus_if.sel_o}, 32'h0);
        checkOutput("rst_strobes", {30'h0, bus_if.read_o, bus_if.write_o}, 32'h0);
        checkOutput("rst_rdata", rdata_o, 32'h0);
        checkOutput("rst_done_err", {30'h0, done, err}, 32'h0);
        mem_read = 1'b0;
        tick();
        tick();
        nRst = 1'b1;
        tick();

        // Aligned read, no wait: done on the third edge.
        mem_read       = 1'b1;
        read_ad        = 32'h0000_0104;
        bus_if.rdata_i = 32'hDEAD_BEEF;
        #1;
        checkOutput("rd_freeze_idle", {31'h0, freeze}, 32'h1);
        tick();
        checkOutput("rd_read_o", {31'h0, bus_if.read_o}, 32'h1);
        checkOutput("rd_write_o", {31'h0, bus_if.write_o}, 32'h0);
        checkOutput("rd_adr", bus_if.adr_o, 32'h0000_0104);
        checkOutput("rd_sel", {28'h0, bus_if.sel_o}, 32'hF);
        checkOutput("rd_freeze_read", {31'h0, freeze}, 32'h1);
        tick();
        checkOutput("rd_read_o_wait", {31'h0, bus_if.read_o}, 32'h0);
        checkOutput("rd_done_wait", {31'h0, done}, 32'h0);
        tick();
        checkOutput("rd_done", {31'h0, done}, 32'h1);
        checkOutput("rd_rdata", rdata_o, 32'hDEAD_BEEF);
        checkOutput("rd_err", {31'h0, err}, 32'h0);
        checkOutput("rd_freeze_done", {31'h0, freeze}, 32'h0);
        mem_read = 1'b0;
        tick();
        checkOutput("rd_done_clear", {31'h0, done}, 32'h0);
        checkOutput("rd_rdata_hold", rdata_o, 32'hDEAD_BEEF);

        // Write with four busy WAIT cycles.
        mem_write      = 1'b1;
        write_ad       = 32'h0000_0200;
        write_data     = 32'h1234_5678;
        bus_if.busy_i  = 1'b1;
        bus_if.rdata_i = 32'h5555_AAAA;
        tick();
        checkOutput("wr_write_o", {31'h0, bus_if.write_o}, 32'h1);
        checkOutput("wr_read_o", {31'h0, bus_if.read_o}, 32'h0);
        checkOutput("wr_adr", bus_if.adr_o, 32'h0000_0200);
        checkOutput("wr_wdata", bus_if.wdata_o, 32'h1234_5678);
        tick();
        checkOutput("wr_write_o_wait", {31'h0, bus_if.write_o}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("wr_wait_done", {31'h0, done}, 32'h0);
            checkOutput("wr_wait_adr", bus_if.adr_o, 32'h0000_0200);
            checkOutput("wr_wait_wdata", bus_if.wdata_o, 32'h1234_5678);
            checkOutput("wr_wait_freeze", {31'h0, freeze}, 32'h1);
            tick();
        end
        checkOutput("wr_wait_done_last", {31'h0, done}, 32'h0);
        bus_if.busy_i = 1'b0;
        tick();
        checkOutput("wr_done", {31'h0, done}, 32'h1);
        checkOutput("wr_err", {31'h0, err}, 32'h0);
        checkOutput("wr_rdata_kept", rdata_o, 32'hDEAD_BEEF);
        mem_write = 1'b0;
        tick();
        checkOutput("wr_done_clear", {31'h0, done}, 32'h0);

        // Both requests high: write wins.
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        read_ad    = 32'h0000_0400;
        write_ad   = 32'h0000_0500;
        write_data = 32'hA5A5_5A5A;
        tick();
        checkOutput("both_write_o", {31'h0, bus_if.write_o}, 32'h1);
        checkOutput("both_read_o", {31'h0, bus_if.read_o}, 32'h0);
        checkOutput("both_adr", bus_if.adr_o, 32'h0000_0500);
        tick();
        checkOutput("both_read_o_wait", {31'h0, bus_if.read_o}, 32'h0);
        tick();
        checkOutput("both_done", {31'h0, done}, 32'h1);
        checkOutput("both_rdata_kept", rdata_o, 32'hDEAD_BEEF);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();

        // Misaligned read: straight to DONE with error.
        mem_read = 1'b1;
        read_ad  = 32'h0000_0102;
        tick();
        checkOutput("mis_done", {31'h0, done}, 32'h1);
        checkOutput("mis_err", {31'h0, err}, 32'h1);
        checkOutput("mis_rdata", rdata_o, 32'h0);
        checkOutput("mis_strobes", {30'h0, bus_if.read_o, bus_if.write_o}, 32'h0);
        checkOutput("mis_adr_kept", bus_if.adr_o, 32'h0000_0500);
        checkOutput("mis_freeze", {31'h0, freeze}, 32'h0);
        mem_read = 1'b0;
        tick();
        checkOutput("mis_done_clear", {31'h0, done}, 32'h0);
        checkOutput("mis_err_hold", {31'h0, err}, 32'h1);

        // Good read clears err and loads new data.
        mem_read       = 1'b1;
        read_ad        = 32'h0000_0008;
        bus_if.rdata_i = 32'hCAFE_F00D;
        tick();
        tick();
        tick();
        checkOutput("rd2_done", {31'h0, done}, 32'h1);
        checkOutput("rd2_err", {31'h0, err}, 32'h0);
        checkOutput("rd2_rdata", rdata_o, 32'hCAFE_F00D);
        mem_read = 1'b0;
        tick();

        // Timeout: busy held, counter 0..4 in WAIT, abort on the fifth busy WAIT cycle.
        mem_read      = 1'b1;
        read_ad       = 32'h0000_0300;
        bus_if.busy_i = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("to_wait_done", {31'h0, done}, 32'h0);
            tick();
        end
        checkOutput("to_wait_done_last", {31'h0, done}, 32'h0);
        checkOutput("to_wait_freeze", {31'h0, freeze}, 32'h1);
        tick();
        checkOutput("to_done", {31'h0, done}, 32'h1);
        checkOutput("to_err", {31'h0, err}, 32'h1);
        checkOutput("to_rdata", rdata_o, 32'h0);
        mem_read      = 1'b0;
        bus_if.busy_i = 1'b0;
        tick();

        // Good read restores rdata before the reset test.
        mem_read       = 1'b1;
        read_ad        = 32'h0000_0010;
        bus_if.rdata_i = 32'h1111_2222;
        tick();
        tick();
        tick();
        checkOutput("rd3_rdata", rdata_o, 32'h1111_2222);
        mem_read = 1'b0;
        tick();

        // Reset while in WAIT.
        mem_read      = 1'b1;
        read_ad       = 32'h0000_0600;
        bus_if.busy_i = 1'b1;
        tick();
        tick();
        checkOutput("rw_adr_before", bus_if.adr_o, 32'h0000_0600);
        #2;
        nRst = 1'b0;
        #1;
        checkOutput("rw_adr", bus_if.adr_o, 32'h0);
        checkOutput("rw_sel", {28'h0, bus_if.sel_o}, 32'h0);
        checkOutput("rw_rdata", rdata_o, 32'h0);
        checkOutput("rw_freeze", {31'h0, freeze}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rw_no_done", {31'h0, done}, 32'h0);
        end
        read_ad        = 32'h0000_0700;
        bus_if.busy_i  = 1'b0;
        bus_if.rdata_i = 32'h0BAD_F00D;
        nRst           = 1'b1;
        tick();
        checkOutput("rw_next_read_o", {31'h0, bus_if.read_o}, 32'h1);
        checkOutput("rw_next_adr", bus_if.adr_o, 32'h0000_0700);
        tick();
        checkOutput("rw_next_wait_done", {31'h0, done}, 32'h0);
        tick();
        checkOutput("rw_next_done", {31'h0, done}, 32'h1);
        checkOutput("rw_next_rdata", rdata_o, 32'h0BAD_F00D);
        checkOutput("rw_next_err", {31'h0, err}, 32'h0);
        mem_read = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
